rename_map_unit: RTL and testbench

//  Parametrised register-rename core: front RAT, retirement RAT and a bit-vector free list.

---
 rtl/rename_map_unit.sv | 119 +++++++++++
 tb/tb_rename_map_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_unit.sv
// Register-rename core: speculative front RAT, retirement RAT and a bit-vector free list.
// Renames one instruction per cycle; a flush rebuilds the front state from the retired state.
module rename_map_unit #(
  parameter int  ARCH_REGS = 32,
  parameter int  PHYS_REGS = 64,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHYS_REGS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          rn_valid,
  input  logic [AW-1:0] rn_src_a,
  input  logic [AW-1:0] rn_src_b,
  input  logic [AW-1:0] rn_dst,
  input  logic          rn_dst_wr,
  output logic          rn_ready,
  output logic [PW-1:0] rn_phys_a,
  output logic [PW-1:0] rn_phys_b,
  output logic [PW-1:0] rn_phys_dst,
  output logic [PW-1:0] rn_old_dst,
  input  logic          cm_valid,
  input  logic [AW-1:0] cm_dst,
  input  logic [PW-1:0] cm_phys,
  input  logic [PW-1:0] cm_old_phys,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  localparam logic [PW:0] SPARE = (PW+1)'(PHYS_REGS - ARCH_REGS);

  logic [PW-1:0]        frat      [ARCH_REGS];
  logic [PW-1:0]        rrat      [ARCH_REGS];
  logic [PW-1:0]        rrat_next [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_vec;
  logic [PHYS_REGS-1:0] free_next;
  logic [PHYS_REGS-1:0] flush_free;
  logic [PW-1:0]        alloc_idx;
  logic [PW:0]          count_next;
  logic                 need;
  logic                 fire;
  logic                 alloc;
  logic                 cm_en;

  assign need     = rn_dst_wr && (rn_dst != '0);
  assign rn_ready = !flush && (!need || (free_count != '0));
  assign fire     = rn_valid && rn_ready;
  assign alloc    = fire && need;
  assign cm_en    = cm_valid && (cm_dst != '0);

  // Lookups read only the registered FRAT, so a source naming rn_dst sees the old mapping.
  assign rn_phys_a   = frat[rn_src_a];
  assign rn_phys_b   = frat[rn_src_b];
  assign rn_old_dst  = frat[rn_dst];
  assign rn_phys_dst = need ? alloc_idx : rn_old_dst;

  always_comb begin
    alloc_idx = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = PW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) rrat_next[i] = rrat[i];
    if (cm_en) rrat_next[cm_dst] = cm_phys;
  end

  // Everything not held by the retired map is free after a flush.
  always_comb begin
    flush_free = '1;
    for (int i = 0; i < ARCH_REGS; i++) flush_free[rrat_next[i]] = 1'b0;
  end

  always_comb begin
    free_next = free_vec;
    if (alloc) free_next[alloc_idx] = 1'b0;
    if (cm_en) free_next[cm_old_phys] = 1'b1;
  end

  always_comb begin
    count_next = free_count;
    case ({cm_en, alloc})
      2'b10:   count_next = free_count + 1'b1;
      2'b01:   count_next = free_count - 1'b1;
      default: count_next = free_count;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        frat[i] <= PW'(i);
        rrat[i] <= PW'(i);
      end
      for (int i = 0; i < PHYS_REGS; i++) free_vec[i] <= (i >= ARCH_REGS);
      free_count <= SPARE;
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= rrat_next[i];
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) frat[i] <= rrat_next[i];
        free_vec   <= flush_free;
        free_count <= SPARE;
      end else begin
        if (alloc) frat[rn_dst] <= alloc_idx;
        free_vec   <= free_next;
        free_count <= count_next;
      end
    end
  end

  a_no_double_free: assert property (@(posedge CLK) disable iff (RESET)
    cm_en |-> !free_vec[cm_old_phys])
    else $error("rename_map_unit: commit releases already-free phys reg %0d", cm_old_phys);

  a_count_matches: assert property (@(posedge CLK) disable iff (RESET)
    free_count == (PW+1)'($countones(free_vec)))
    else $error("rename_map_unit: free_count %0d disagrees with free list", free_count);

endmodule

// File: tb/tb_rename_map_unit.sv
// Bench for rename_map_unit: directed scenarios plus random traffic, scored against a
// table-level model of the rename maps, free set and an in-order commit queue.
module tb_rename_map_unit;
  localparam int AR = 32;
  localparam int PR = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       rn_valid = 1'b0, rn_dst_wr = 1'b0, rn_ready;
  logic [4:0] rn_src_a = '0, rn_src_b = '0, rn_dst = '0;
  logic [5:0] rn_phys_a, rn_phys_b, rn_phys_dst, rn_old_dst;
  logic       cm_valid = 1'b0, flush = 1'b0;
  logic [4:0] cm_dst = '0;
  logic [5:0] cm_phys = '0, cm_old_phys = '0;
  logic [6:0] free_count;

  rename_map_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .CLK(CLK), .RESET(RESET),
    .rn_valid(rn_valid), .rn_src_a(rn_src_a), .rn_src_b(rn_src_b), .rn_dst(rn_dst),
    .rn_dst_wr(rn_dst_wr), .rn_ready(rn_ready), .rn_phys_a(rn_phys_a), .rn_phys_b(rn_phys_b),
    .rn_phys_dst(rn_phys_dst), .rn_old_dst(rn_old_dst),
    .cm_valid(cm_valid), .cm_dst(cm_dst), .cm_phys(cm_phys), .cm_old_phys(cm_old_phys),
    .flush(flush), .free_count(free_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ready;
    logic [5:0] pa, pb, pdst, old;
    logic       chk_dst;
    logic [6:0] fc;
  } exp_t;

  typedef struct {
    logic [4:0] dst;
    logic [5:0] nw, old;
  } rob_t;

  exp_t sb[$];
  rob_t rob[$];
  int   m_frat[AR];
  int   m_rrat[AR];
  bit   m_free[PR];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic void model_reset();
    for (int i = 0; i < AR; i++) begin
      m_frat[i] = i;
      m_rrat[i] = i;
    end
    for (int p = 0; p < PR; p++) m_free[p] = (p >= AR);
    rob.delete();
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int p = 0; p < PR; p++) if (m_free[p]) c++;
    return c;
  endfunction

  function automatic int model_lowest();
    for (int p = 0; p < PR; p++) if (m_free[p]) return p;
    return -1;
  endfunction

  function automatic exp_t make_exp(input int a, input int b, input int d, input bit wr,
                                    input bit fl);
    exp_t e;
    bit   need;
    int   cnt;
    need      = wr && (d != 0);
    cnt       = model_count();
    e.ready   = !fl && (!need || cnt != 0);
    e.pa      = 6'(m_frat[a]);
    e.pb      = 6'(m_frat[b]);
    e.old     = 6'(m_frat[d]);
    e.chk_dst = !need || cnt != 0;
    e.pdst    = need ? 6'(model_lowest()) : 6'(m_frat[d]);
    e.fc      = 7'(cnt);
    return e;
  endfunction

  // cm: 0 = no commit, 1 = commit oldest renamed instruction, 2 = commit to r0 (ignored)
  task automatic do_cycle(input bit v, input int a, input int b, input int d, input bit wr,
                          input int cm, input bit fl);
    exp_t e;
    rob_t c;
    int   pdst;
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    rn_valid  = v;
    rn_src_a  = 5'(a);
    rn_src_b  = 5'(b);
    rn_dst    = 5'(d);
    rn_dst_wr = wr;
    flush     = fl;
    cm_valid  = 1'b0;
    cm_dst    = '0;
    cm_phys   = '0;
    cm_old_phys = '0;
    if (cm == 1 && rob.size() > 0) begin
      c = rob.pop_front();
      cm_valid = 1'b1;
      cm_dst = c.dst;
      cm_phys = c.nw;
      cm_old_phys = c.old;
    end else if (cm == 2) begin
      cm_valid = 1'b1;
      cm_phys = 6'($urandom);
      cm_old_phys = 6'($urandom);
    end
    e = make_exp(a, b, d, wr, fl);
    sb.push_back(e);
    pdst = int'(e.pdst);
    if (cm_valid && cm_dst != 0) begin
      m_rrat[cm_dst] = int'(cm_phys);
      m_free[cm_old_phys] = 1'b1;
    end
    if (fl) begin
      for (int i = 0; i < AR; i++) m_frat[i] = m_rrat[i];
      for (int p = 0; p < PR; p++) m_free[p] = 1'b1;
      for (int i = 0; i < AR; i++) m_free[m_rrat[i]] = 1'b0;
      rob.delete();
    end else if (v && e.ready && wr && d != 0) begin
      rob.push_back('{dst: 5'(d), nw: 6'(pdst), old: 6'(m_frat[d])});
      m_frat[d] = pdst;
      m_free[pdst] = 1'b0;
    end
  endtask

  // Reset is raised mid-cycle; the monitor samples before any further clock edge.
  task automatic do_reset_mid();
    exp_t e;
    int   a, b, d;
    @(posedge CLK);
    #1;
    a = $urandom_range(0, AR-1);
    b = $urandom_range(0, AR-1);
    d = $urandom_range(0, AR-1);
    rn_valid = 1'b0; rn_dst_wr = 1'b0; cm_valid = 1'b0; flush = 1'b0;
    rn_src_a = 5'(a); rn_src_b = 5'(b); rn_dst = 5'(d);
    RESET = 1'b1;
    model_reset();
    e = make_exp(a, b, d, 1'b0, 1'b0);
    sb.push_back(e);
  endtask

  function automatic void chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rn_ready", int'(rn_ready), int'(e.ready));
      chk("rn_phys_a", int'(rn_phys_a), int'(e.pa));
      chk("rn_phys_b", int'(rn_phys_b), int'(e.pb));
      chk("rn_old_dst", int'(rn_old_dst), int'(e.old));
      chk("free_count", int'(free_count), int'(e.fc));
      if (e.chk_dst) chk("rn_phys_dst", int'(rn_phys_dst), int'(e.pdst));
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    model_reset();
    do_reset_mid();
    // first rename: r3 -> 32, then r3 reads back 32
    do_cycle(1, 3, 0, 3, 1, 0, 0);
    do_cycle(1, 3, 3, 0, 0, 0, 0);
    // exhaust the free list on r5, then a non-writing rename still fires
    do_reset_mid();
    for (int i = 0; i < 32; i++) do_cycle(1, 5, 5, 5, 1, 0, 0);
    do_cycle(1, 5, 0, 5, 1, 0, 0);
    do_cycle(1, 1, 2, 5, 0, 0, 0);
    // a commit at empty frees phys 5, allocatable the next cycle
    do_cycle(1, 5, 0, 5, 1, 1, 0);
    do_cycle(1, 5, 0, 5, 1, 0, 0);
    do_cycle(0, 5, 0, 5, 0, 0, 0);
    // r7->32, r8->33, commit r7, flush
    do_reset_mid();
    do_cycle(1, 7, 0, 7, 1, 0, 0);
    do_cycle(1, 8, 0, 8, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    do_cycle(1, 7, 8, 9, 1, 0, 1);
    do_cycle(0, 7, 8, 0, 0, 0, 0);
    // destination r0 never allocates
    do_cycle(1, 0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    // flush with a same-cycle commit
    do_cycle(1, 4, 0, 4, 1, 0, 0);
    do_cycle(1, 6, 0, 6, 1, 0, 0);
    do_cycle(0, 4, 6, 0, 0, 1, 1);
    do_cycle(0, 4, 6, 0, 0, 0, 0);
    // reset in the middle of a burst
    for (int i = 0; i < 10; i++) do_cycle(1, $urandom_range(0, 31), 0, $urandom_range(1, 31), 1, 0, 0);
    do_reset_mid();
    do_cycle(0, 3, 9, 12, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      int cm;
      if (i == 1700) begin
        do_reset_mid();
        continue;
      end
      r  = $urandom_range(0, 99);
      cm = (r < 40) ? 1 : (r < 45) ? 2 : 0;
      do_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 9) < 8, cm, $urandom_range(0, 99) < 3);
    end
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
